// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Bundle between the frame producer, the scan controller and the shared
//   7-segment decoder / anode drivers.
//   Handshake: there is no valid/ready pair. 'load' is a one-cycle strobe
//   that is always accepted on the rising edge where it is high. 'en' is a
//   level. All outputs are registered-state functions, stable for a full cycle.
//   Signals:
//     en         producer -> ctrl   scan enable (0 = dark)
//     load       producer -> ctrl   capture wr_data into shadow buffer
//     wr_data    producer -> ctrl   4*NDIG digit codes, digit i at [4i+3:4i]
//     code       ctrl -> decoder    {a,b,c,d}, 4'h0 = all segments off
//     dig_en     ctrl -> anodes     active-low digit enables
//     pending    ctrl -> producer   shadow holds an unapplied frame
//     frame_done ctrl -> producer   one-cycle pulse at each frame wrap
interface seg_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              en;
  logic              load;
  logic [4*NDIG-1:0] wr_data;
  logic [3:0]        code;
  logic [NDIG-1:0]   dig_en;
  logic              pending;
  logic              frame_done;

  modport master (
    output en, load, wr_data,
    input  code, dig_en, pending, frame_done
  );

  modport slave (
    input  en, load, wr_data,
    output code, dig_en, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for NDIG common-anode 7-segment digits
//   sharing one decoder. Each slot is PRESCALE cycles: BLANK dark cycles
//   followed by the digit being lit. New frames are written to a shadow
//   buffer and copied to the active buffer only at the frame wrap.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  seg_scan_ctrl_if slave modport (en/load/wr_data in,
//          code/dig_en/pending/frame_done out)
module seg_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 16
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] active_q, active_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;

  logic slot_end;
  logic frame_wrap;
  logic show;

  assign slot_end   = (cnt_q == CW'(PRESCALE - 1));
  assign frame_wrap = bus.en && slot_end && (idx_q == IW'(NDIG - 1));

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    if (!bus.en) begin
      // Disabled: park at digit 0, start of slot, so re-enable begins blanked.
      cnt_d = '0;
      idx_d = '0;
    end else begin
      frame_done_d = frame_wrap;
      if (slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (frame_wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    // A load on the wrap edge still lands in the shadow and keeps pending set,
    // so it is applied at the following wrap rather than lost.
    if (bus.load) begin
      shadow_d  = bus.wr_data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Outputs come only from registers; en=0 parks cnt at 0, which is inside
  // the blank phase, so the display is dark whenever scanning is stopped.
  assign show           = (cnt_q >= CW'(BLANK));
  assign bus.code       = show ? active_q[{idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.dig_en     = show ? ~(NDIG'(1) << idx_q) : '1;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  seg_scan_ctrl_if #(.NDIG(4)) bus ();

  seg_scan_ctrl #(
    .NDIG    (4),
    .PRESCALE(8),
    .BLANK   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag, input logic exp_pend);
    chk({tag, "_dig_en"}, 16'(bus.dig_en), 16'hF);
    chk({tag, "_code"}, 16'(bus.code), 16'h0);
    chk({tag, "_pending"}, 16'(bus.pending), 16'(exp_pend));
    chk({tag, "_frame_done"}, 16'(bus.frame_done), 16'h0);
  endtask

  // Walks one full frame (4 slots x 8 cycles) starting at cnt=0, idx=0,
  // checking every cycle. Optionally strobes load at slot ls, count lc.
  task automatic run_frame(input string tag, input logic [15:0] data, input logic fd,
                           input logic pend, input int ls, input int lc,
                           input logic [15:0] ld);
    logic       exp_pend;
    logic [3:0] exp_en;
    logic [3:0] exp_code;
    exp_pend = pend;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 8; c++) begin
        if (c < 2) begin
          exp_en   = 4'hF;
          exp_code = 4'h0;
        end else begin
          exp_en   = ~(4'b0001 << i);
          exp_code = 4'((data >> (4 * i)) & 16'hF);
        end
        chk({tag, "_dig_en"}, 16'(bus.dig_en), 16'(exp_en));
        chk({tag, "_code"}, 16'(bus.code), 16'(exp_code));
        chk({tag, "_pending"}, 16'(bus.pending), 16'(exp_pend));
        chk({tag, "_frame_done"}, 16'(bus.frame_done), 16'(fd && i == 0 && c == 0));
        if (i == ls && c == lc) begin
          bus.load    = 1'b1;
          bus.wr_data = ld;
          step();
          bus.load = 1'b0;
          exp_pend = 1'b1;
        end else begin
          step();
        end
      end
    end
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.wr_data = '0;

    // reset held 3 cycles with en and load active
    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.load    = 1'b1;
    bus.wr_data = 16'hFFFF;
    repeat (3) begin
      step();
      chk_dark("reset", 1'b0);
    end
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    step();
    chk_dark("post_reset", 1'b0);

    // load while disabled, then start scanning
    bus.load    = 1'b1;
    bus.wr_data = 16'h9A3F;
    step();
    bus.load = 1'b0;
    chk("load_pending", 16'(bus.pending), 16'h1);
    bus.en = 1'b1;

    run_frame("f1_blank", 16'h0000, 1'b0, 1'b1, -1, 0, 16'h0);
    run_frame("f2_basic", 16'h9A3F, 1'b1, 1'b0, -1, 0, 16'h0);
    // double buffer: load mid-frame at slot 2
    run_frame("f3_dbuf", 16'h9A3F, 1'b1, 1'b0, 2, 0, 16'h1234);
    // load exactly on the wrap edge while nothing is pending
    run_frame("f4_new", 16'h1234, 1'b1, 1'b0, 3, 7, 16'h7777);
    // collision: 7777 pending, 5555 loaded on the wrap edge
    run_frame("f5_hold", 16'h1234, 1'b1, 1'b1, 3, 7, 16'h5555);
    run_frame("f6_sevens", 16'h7777, 1'b1, 1'b1, -1, 0, 16'h0);
    run_frame("f7_fives", 16'h5555, 1'b1, 1'b0, -1, 0, 16'h0);

    // enable gating: move to idx=1, cnt=5
    repeat (13) step();
    chk("gate_pre_dig_en", 16'(bus.dig_en), 16'hD);
    chk("gate_pre_code", 16'(bus.code), 16'h5);
    bus.en      = 1'b0;
    bus.load    = 1'b1;
    bus.wr_data = 16'h8421;
    step();
    bus.load = 1'b0;
    chk_dark("gate_off", 1'b1);
    repeat (9) begin
      step();
      chk_dark("gate_hold", 1'b1);
    end
    bus.en = 1'b1;
    run_frame("f8_restart", 16'h5555, 1'b0, 1'b1, -1, 0, 16'h0);
    run_frame("f9_applied", 16'h8421, 1'b1, 1'b0, -1, 0, 16'h0);

    // random invariants
    for (int n = 0; n < 1000; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      bus.en      = ($urandom_range(0, 7) != 0);
      bus.load    = ($urandom_range(0, 9) == 0);
      bus.wr_data = 16'($urandom);
      step();
      chk("inv_one_digit", 16'($countones(~bus.dig_en) <= 1), 16'h1);
      if (bus.dig_en == 4'hF) chk("inv_dark_code", 16'(bus.code), 16'h0);
    end
    rst      = 1'b0;
    bus.load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
